// File: rtl/maquina_escritura.sv
// maquina_escritura: write sequencer that walks the eleven RTC registers with setup/strobe/hold phases.
// Optional per-slot skipping is enabled with MAQUINA_ESCRITURA_MASK_EN (adds field_mask input).
module maquina_escritura #(
    parameter int unsigned SETUP_CYCLES = 8,
    parameter int unsigned WR_CYCLES    = 16,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  data_in,
`ifdef MAQUINA_ESCRITURA_MASK_EN
    input  logic [10:0] field_mask,
`endif
    output logic [3:0]  reg_sel,
    output logic [7:0]  address,
    output logic [7:0]  data_out,
    output logic        wr_en,
    output logic        bus_en,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, ADDR, WRITE, HOLD, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       slot_q, slot_d;
    logic [7:0]       data_q, data_d;
    logic [10:0]      mask_q, mask_d;
    logic [10:0]      mask_in;
    logic [4:0]       first, following;
    logic [CNT_W-1:0] last_cnt;
    logic             phase_end;
    logic             on_bus;

`ifdef MAQUINA_ESCRITURA_MASK_EN
    assign mask_in = field_mask;
`else
    assign mask_in = '1;
`endif

    // {found, index} of the lowest enabled slot at or above 'from'
    function automatic logic [4:0] seek(input logic [10:0] m, input logic [3:0] from);
        seek = 5'd0;
        for (int i = 10; i >= 0; i--)
            if (m[i] && 4'(i) >= from) seek = {1'b1, 4'(i)};
    endfunction

    assign first     = seek(mask_in, 4'd0);
    assign following = seek(mask_q, slot_q + 4'd1);
    assign last_cnt  = (state_q == ADDR)  ? CNT_W'(SETUP_CYCLES - 1) :
                       (state_q == WRITE) ? CNT_W'(WR_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);
    assign phase_end = cnt_q == last_cnt;
    assign on_bus    = state_q == ADDR || state_q == WRITE || state_q == HOLD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        slot_d  = slot_q;
        data_d  = data_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                slot_d = '0;
                data_d = '0;
                mask_d = mask_in;
                if (start && !abort) begin
                    state_d = first[4] ? ADDR : DONE;
                    slot_d  = first[3:0];
                end
            end
            ADDR: if (phase_end) begin
                state_d = WRITE;
                cnt_d   = '0;
                data_d  = data_in;
            end
            WRITE: if (phase_end) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (phase_end) begin
                state_d = following[4] ? ADDR : DONE;
                slot_d  = following[4] ? following[3:0] : slot_q;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                data_d  = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort && on_bus) begin
            state_d = IDLE;
            cnt_d   = '0;
            slot_d  = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    // slots 0..7 map to 21h..28h, slots 8..10 to 41h..43h
    assign address  = !on_bus ? 8'h00 : (slot_q < 4'd8) ? 8'h21 + {4'h0, slot_q} : 8'h39 + {4'h0, slot_q};
    assign reg_sel  = on_bus ? slot_q : 4'd0;
    assign data_out = on_bus ? data_q : 8'h00;
    assign wr_en    = state_q == WRITE;
    assign bus_en   = on_bus;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
endmodule

// File: tb/tb_maquina_escritura.sv
// tb_maquina_escritura: randomized scoreboard bench; expected bus writes and done times come from a slot-list model.
module tb_maquina_escritura;
    localparam int S = 8, W = 16, H = 8, P = S + W + H;
    localparam logic [7:0] AMAP [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

    typedef struct {
        logic [7:0] addr;
        logic [3:0] sel;
        logic [7:0] data;
        int         wr;
        int         bus;
    } ev_t;

    logic       clk = 0, reset = 1, start = 0, abort = 0;
    logic [7:0] data_in;
    logic [3:0] reg_sel;
    logic [7:0] address, data_out;
    logic       wr_en, bus_en, busy, done;
`ifdef MAQUINA_ESCRITURA_MASK_EN
    logic [10:0] field_mask = '1;
`endif

    int         total = 0, bad = 0, ecnt = 0, mode = 0;
    logic [7:0] cval = 8'h5A;
    logic [7:0] dtab [16];
    bit         mon_en = 0;
    ev_t        evq [$];
    int         doneq [$];

    maquina_escritura dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .data_in(data_in),
`ifdef MAQUINA_ESCRITURA_MASK_EN
        .field_mask(field_mask),
`endif
        .reg_sel(reg_sel), .address(address), .data_out(data_out),
        .wr_en(wr_en), .bus_en(bus_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    // register file stand-in: value depends on the slot the DUT selects
    always_comb data_in = (mode == 0) ? cval : (mode == 1) ? 8'h10 + {4'h0, reg_sel} : dtab[reg_sel];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int s);
        return (mode == 0) ? cval : (mode == 1) ? 8'(8'h10 + s) : dtab[s];
    endfunction

    task automatic wait_edge(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_address"}, address, 0);
        chk({nm, "_data_out"}, data_out, 0);
        chk({nm, "_reg_sel"}, reg_sel, 0);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_bus_en"}, bus_en, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    // cut_t: relative cycle (0 = first ADDR cycle) during which abort/reset is held; -1 for none
    task automatic run_seq(input logic [10:0] m, input int cut_t, input bit cut_rst, input int restart_t);
        int  slots [$];
        int  e, t0, off, endt;
        ev_t ev;
`ifdef MAQUINA_ESCRITURA_MASK_EN
        field_mask = m;
`else
        m = '1;
`endif
        for (int s = 0; s < 11; s++) if (m[s]) slots.push_back(s);
        start = 1;
        e = ecnt + 1;
        foreach (slots[k]) begin
            t0 = k * P;
            if (cut_t >= 0 && cut_t < t0) break;
            ev.addr = AMAP[slots[k]];
            ev.sel  = 4'(slots[k]);
            ev.data = dat(slots[k]);
            ev.wr   = W;
            ev.bus  = P;
            if (cut_t >= 0 && cut_t < t0 + P) begin
                off    = cut_t - t0;
                ev.bus = off + 1;
                ev.wr  = (off < S) ? 0 : (off - S + 1 > W) ? W : off - S + 1;
            end
            evq.push_back(ev);
        end
        if (cut_t < 0) doneq.push_back(e + slots.size() * P);
        wait_edge(e);
        start = 0;
`ifdef MAQUINA_ESCRITURA_MASK_EN
        field_mask = 11'($urandom);
`endif
        if (restart_t >= 0) begin
            wait_edge(e + restart_t);
            start = 1;
            wait_edge(e + restart_t + 1);
            start = 0;
        end
        if (cut_t >= 0) begin
            wait_edge(e + cut_t);
            if (cut_rst) reset = 1;
            else abort = 1;
            wait_edge(e + cut_t + 1);
            reset = 0;
            abort = 0;
            chk_idle(cut_rst ? "after_reset" : "after_abort");
            endt = e + cut_t + 4;
        end else endt = e + slots.size() * P + 4;
        wait_edge(endt);
        chk("pending_writes", evq.size(), 0);
        chk("pending_done", doneq.size(), 0);
    endtask

    // monitor: a bus window ends when bus_en falls or the address moves to the next slot
    initial begin
        logic       pbus = 0, unstable = 0;
        int         blen = 0, wlen = 0, dexp;
        logic [7:0] caddr = 0, cdata = 0;
        logic [3:0] csel = 0;
        ev_t        ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pbus && (!bus_en || address != caddr)) begin
                    chk("write_expected", int'(evq.size() > 0), 1);
                    if (evq.size() > 0) begin
                        ev = evq.pop_front();
                        chk("addr", caddr, ev.addr);
                        chk("reg_sel", csel, ev.sel);
                        chk("bus_len", blen, ev.bus);
                        chk("wr_len", wlen, ev.wr);
                        if (ev.wr > 0) chk("data", cdata, ev.data);
                        chk("stable_during_strobe", unstable, 0);
                    end
                    blen = 0;
                    wlen = 0;
                    unstable = 0;
                end
                if (bus_en) begin
                    if (blen == 0) begin
                        caddr = address;
                        csel  = reg_sel;
                    end
                    chk("busy_with_bus", busy, 1);
                    blen++;
                end
                if (wr_en) begin
                    if (wlen == 0) cdata = data_out;
                    else if (data_out != cdata || address != caddr) unstable = 1;
                    chk("bus_with_strobe", bus_en, 1);
                    wlen++;
                end
                if (done) begin
                    chk("done_expected", int'(doneq.size() > 0), 1);
                    if (doneq.size() > 0) begin
                        dexp = doneq.pop_front();
                        chk("done_time", ecnt, dexp);
                    end
                    chk("done_bus_en", bus_en, 0);
                    chk("done_busy", busy, 1);
                end
                pbus = bus_en;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) dtab[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset = 0;
        mon_en = 1;
        mode = 0; cval = 8'h5A;
        run_seq('1, -1, 0, -1);
        mode = 1;
        run_seq('1, -1, 0, -1);
        mode = 2;
        run_seq('1, -1, 0, 4 * P + 5);
        mode = 0; cval = 8'($urandom);
        run_seq('1, 2 * P + S + 2, 0, -1);
        mode = 1;
        run_seq('1, -1, 0, -1);
        mode = 2;
        run_seq('1, 9 * P + S + W + $urandom_range(0, H - 1), 1, -1);
        start = 1;
        abort = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("start_abort_busy", busy, 0);
            chk("start_abort_bus_en", bus_en, 0);
        end
        start = 0;
        abort = 0;
`ifdef MAQUINA_ESCRITURA_MASK_EN
        mode = 1;
        run_seq(11'b10000000101, -1, 0, -1);
        run_seq(11'b0, -1, 0, -1);
        mode = 2;
        run_seq(11'($urandom), -1, 0, -1);
`endif
        wait_edge(ecnt + 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/maquina_escritura.md
Name: maquina_escritura

Overview:
- Write-side sequencer for the RTC register bus; counterpart of the read-address sequencer that polls the same eleven registers.
- On a start request it walks the fixed register list and drives address and data with a write strobe for each register.
- It signals busy/done to the control FSM.
- It sits between the user-edit register file (source of the time/date/timer values) and the RTC bus driver.

Parameters:
- SETUP_CYCLES, 8: cycles address/data are driven before the strobe (≥1).
- WR_CYCLES, 16: cycles wr_en is held high per register (≥1).
- HOLD_CYCLES, 8: cycles address/data are held after the strobe falls (≥1).
- CNT_W, 8: width of the phase counter; each *_CYCLES must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a full write sequence; sampled only in IDLE
- abort  in  1  synchronous cancel of a running sequence
- data_in  in  8  value for the register selected by reg_sel (combinational from the register file)
- reg_sel  out  4  slot index 0..10 of the register being written
- address  out  8  RTC register address
- data_out  out  8  RTC write data
- wr_en  out  1  write strobe
- bus_en  out  1  high while address/data_out are valid and owned by this block
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the last register completes

Behaviour:
- Slot→address map: 0..7 → 8'h21..8'h28; 8 → 8'h41; 9 → 8'h42; 10 → 8'h43.
- Reset values, also applied whenever in IDLE:
  - address=8'h00, data_out=8'h00, reg_sel=0
  - wr_en=0, bus_en=0, busy=0, done=0
  - phase counter=0
- States: IDLE, ADDR, WRITE, HOLD, DONE.
- IDLE:
  - start=1 → ADDR with slot=0 on the next edge.
  - busy, bus_en and address become valid the cycle after start is sampled (latency 1).
- ADDR:
  - address = map(slot), reg_sel = slot, bus_en=1, wr_en=0.
  - Lasts SETUP_CYCLES.
  - On the exit edge, data_out <= data_in; state → WRITE.
- WRITE: wr_en=1 for exactly WR_CYCLES cycles; address and data_out stable.
- HOLD:
  - wr_en=0 for HOLD_CYCLES; address and data_out stable.
  - Then slot<10 → slot+1, ADDR; slot==10 → DONE.
- DONE:
  - One cycle: done=1, busy=1, bus_en=0.
  - Then → IDLE.
- Per-slot length is SETUP+WR+HOLD cycles. A full sequence occupies 1 + 11·(SETUP+WR+HOLD) + 1 cycles from start sample to done.
- The phase counter reloads to 0 at every state change.
- Slot wraps never occur: there are no slots beyond 10.
- start while busy=1 is ignored and not queued.
- abort=1 in ADDR/WRITE/HOLD:
  - → IDLE on the next edge; all outputs take IDLE values.
  - No done pulse; a partially written register is left as-is.
- abort=1 in DONE or IDLE has no effect.
- start and abort high together in IDLE: abort wins and the block stays IDLE.
- reset mid-sequence: immediate return to IDLE values on the next edge, independent of state. reset dominates abort and start.

Optional Feature:
- Macro MAQUINA_ESCRITURA_MASK_EN.
- When defined:
  - Adds input field_mask [10:0].
  - The mask is sampled on the start edge and held for the whole sequence.
  - Slots whose mask bit is 0 are skipped with zero bus cycles (the next enabled slot is selected directly).
  - All-zero mask: start → DONE after one cycle (done pulse at cycle 2), no bus activity.
- When undefined: port absent; all 11 slots are always written.

Test Plan:
- Defaults, start pulse with data_in=8'h5A constant → addresses 21..28,41,42,43 in order, each with 32 cycles of bus_en and wr_en high for 16. data_out=8'h5A during every strobe. done pulses exactly once, 354 cycles after start is sampled.
- data_in driven as {4'h0,reg_sel}+8'h10 → data_out sequence 8'h10..8'h1A paired with the matching addresses. data_out never changes while wr_en=1.
- start re-asserted during slot 4 → sequence unaffected, no second sequence afterwards, single done pulse.
- abort asserted during the 3rd WRITE cycle of slot 2 (address 8'h23) → next cycle wr_en=0, bus_en=0, busy=0, address=8'h00. No done pulse; a fresh start then begins again at 8'h21.
- reset asserted during HOLD of slot 9 → all outputs at reset values next cycle; start and abort held high together in IDLE → block stays IDLE.
- With MAQUINA_ESCRITURA_MASK_EN, field_mask=11'b10000000101 → only 8'h21, 8'h23 and 8'h43 are written, back-to-back, followed by done. field_mask=0 → done pulse with bus_en never asserted.
